// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbitration slice.
//
// Contents:
//   uart_byte_t       - one byte on the UART byte-stream interface
//   arb_state_e       - arbiter packet states (IDLE, HDR, DATA)
//   HDR_BASE_DEFAULT  - default header base byte; low 3 bits carry the source
//   IDX_W             - width of a source index (supports up to MAX_SRC)
//   wrapInc()         - round-robin pointer advance with wrap at n
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam uart_byte_t HDR_BASE_DEFAULT = 8'hF0;

    // Source indices are always carried in 3 bits so the header byte layout
    // is identical for every N_SRC.
    localparam int IDX_W   = 3;
    localparam int MAX_SRC = 8;

    // Advance a source index by one, wrapping to zero after source n-1.
    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] idx,
                                                 input int               n);
        logic [IDX_W-1:0] result;
        if (int'(idx) >= n - 1) begin
            result = '0;
        end else begin
            result = idx + IDX_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set-bit finder. Starting at the pointer
// position and scanning upward with wrap, returns the first requesting bit.
//
// Ports:
//   req_i     in  N      request vector
//   ptr_i     in  IDX_W  scan start position (0..N-1)
//   onehot_o  out N      one-hot winner, 0 when no request
//   idx_o     out IDX_W  binary index of the winner, 0 when no request
//   any_o     out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0] w_upperMask;
    logic [N-1:0] w_upperReq;
    logic [N-1:0] w_scanVec;

    // Split the requests into those at or above the pointer and the rest.
    // Searching the upper half first, then the full vector, gives the
    // wrap-around scan order without any modulo arithmetic.
    always_comb begin
        w_upperMask = '0;
        for (int k = 0; k < N; k++) begin
            w_upperMask[k] = (k >= int'(ptr_i));
        end
        w_upperReq = req_i & w_upperMask;
        w_scanVec  = (|w_upperReq) ? w_upperReq : req_i;
    end

    // Lowest set bit of the selected scan vector is the winner.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && w_scanVec[k]) begin
                any_o       = 1'b1;
                onehot_o[k] = 1'b1;
                idx_o       = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Shares one byte-serial UART transmitter between N_SRC packet requesters.
// One source is granted at a time (round-robin) for a whole packet, with an
// optional source-ID header byte in front of each packet. A stall watchdog
// aborts a packet whose owner stops presenting bytes for too long.
//
// Ports:
//   clk_i       in  1        clock
//   rst_ni      in  1        asynchronous active-low reset
//   srst_i      in  1        synchronous reset, same effect as rst_ni
//   req_val_i   in  N_SRC    per-source byte valid
//   req_data_i  in  N_SRC*8  per-source byte, source k at [8k+7:8k]
//   req_last_i  in  N_SRC    per-source end-of-packet flag
//   req_rdy_o   out N_SRC    per-source ready, at most one bit set
//   tx_val_o    out 1        byte valid to transmitter
//   tx_data_o   out 8        byte to transmitter
//   tx_rdy_i    in  1        transmitter ready
//   tx_avail_i  in  1        link available; gates new packet starts only
//   grant_o     out N_SRC    one-hot current owner, 0 when idle
//   busy_o      out 1        packet in progress
//   abort_o     out 1        one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int         N_SRC     = 2,
    parameter int         HDR_EN    = 1,
    parameter uart_byte_t HDR_BASE  = HDR_BASE_DEFAULT,
    parameter int         STALL_MAX = 4096
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               srst_i,
    input  logic [N_SRC-1:0]   req_val_i,
    input  logic [N_SRC*8-1:0] req_data_i,
    input  logic [N_SRC-1:0]   req_last_i,
    output logic [N_SRC-1:0]   req_rdy_o,
    output logic               tx_val_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_rdy_i,
    input  logic               tx_avail_i,
    output logic [N_SRC-1:0]   grant_o,
    output logic               busy_o,
    output logic               abort_o
);

    // One extra bit so STALL_MAX-1 always fits, even for powers of two.
    localparam int SW = $clog2(STALL_MAX) + 1;

    arb_state_e       r_state;
    arb_state_e       w_nextState;
    logic [N_SRC-1:0] r_grant;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [SW-1:0]    r_stall;

    logic [N_SRC-1:0] w_pickOneHot;
    logic [IDX_W-1:0] w_pickIdx;
    logic             w_pickAny;
    logic             w_gVal;
    logic             w_gLast;
    uart_byte_t       w_gData;
    logic             w_start;
    logic             w_xfer;
    logic             w_done;
    logic             w_abort;

    rr_pick #(
        .N (N_SRC)
    ) u_pick (
        .req_i    (req_val_i),
        .ptr_i    (r_ptr),
        .onehot_o (w_pickOneHot),
        .idx_o    (w_pickIdx),
        .any_o    (w_pickAny)
    );

    // Select the granted source's valid/last/data using the one-hot grant.
    // Non-granted sources are masked out completely, so nothing they drive
    // can leak onto the transmitter side while a packet is in flight.
    always_comb begin
        w_gVal  = |(req_val_i & r_grant);
        w_gLast = |(req_last_i & r_grant);
        w_gData = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_grant[k]) begin
                w_gData = req_data_i[8*k +: 8];
            end
        end
    end

    // Packet-level events. The watchdog only counts cycles where the owner
    // has nothing to offer; valid-but-not-ready is transmitter back-pressure
    // and must never abort a packet.
    always_comb begin
        w_start = (r_state == IDLE) && tx_avail_i && w_pickAny;
        w_xfer  = (r_state == DATA) && w_gVal && tx_rdy_i;
        w_done  = w_xfer && w_gLast;
        w_abort = (r_state == DATA) && !w_gVal &&
                  (r_stall == SW'(STALL_MAX - 1));
    end

    // State register. The synchronous reset wins over any pending
    // transition and simply truncates a packet in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else if (srst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start a packet from IDLE when the link allows it,
    // leave HDR once the header is accepted, and leave DATA on the last
    // byte or on a watchdog abort.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = (HDR_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                if (tx_rdy_i) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_done || w_abort) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic: header byte in HDR, pure pass-through of the owner in
    // DATA, everything quiet in IDLE.
    always_comb begin
        req_rdy_o = '0;
        tx_val_o  = 1'b0;
        tx_data_o = '0;
        abort_o   = 1'b0;
        case (r_state)
            HDR: begin
                tx_val_o  = 1'b1;
                tx_data_o = {HDR_BASE[7:3], r_idx};
            end
            DATA: begin
                tx_val_o  = w_gVal;
                tx_data_o = w_gData;
                req_rdy_o = r_grant & {N_SRC{tx_rdy_i}};
                abort_o   = w_abort;
            end
            default: begin
                req_rdy_o = '0;
            end
        endcase
        grant_o = r_grant;
        busy_o  = (r_state != IDLE);
    end

    // Grant, index, round-robin pointer and stall counter. The pointer only
    // moves when a packet ends (normally or by abort) so that the source
    // after the last owner gets first chance at the next packet. The stall
    // counter is held at zero outside DATA, which also clears it on entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_stall <= '0;
        end else if (srst_i) begin
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_stall <= '0;
        end else if (w_start) begin
            r_grant <= w_pickOneHot;
            r_idx   <= w_pickIdx;
            r_stall <= '0;
        end else if (w_done || w_abort) begin
            r_grant <= '0;
            r_ptr   <= wrapInc(r_idx, N_SRC);
            r_stall <= '0;
        end else if (r_state == DATA) begin
            if (w_xfer) begin
                r_stall <= '0;
            end else if (!w_gVal) begin
                r_stall <= r_stall + SW'(1);
            end
        end else begin
            r_stall <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
// Directed bench for uart_tx_arb (N_SRC=2, header on, STALL_MAX=16).
// Each source is fed from its own byte queue; every byte expected on the
// transmitter side is pushed into a scoreboard queue in arbitration order
// and a negedge monitor pops and compares on each tx handshake.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N = 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } srcItem_t;

    typedef struct {
        logic [7:0]   data;
        logic [N-1:0] grant;
    } expItem_t;

    logic           clk     = 1'b0;
    logic           rstN    = 1'b0;
    logic           srst    = 1'b0;
    logic [N-1:0]   reqVal  = '0;
    logic [N*8-1:0] reqData = '0;
    logic [N-1:0]   reqLast = '0;
    logic [N-1:0]   reqRdy;
    logic           txVal;
    logic [7:0]     txData;
    logic           txRdy   = 1'b1;
    logic           txAvail = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;
    logic           abortP;

    srcItem_t srcQ0[$];
    srcItem_t srcQ1[$];
    expItem_t expQ[$];

    logic [N-1:0] hs = '0;
    int  rdyMode    = 0;
    int  rdyCnt     = 0;
    int  checkCount = 0;
    int  passCount  = 0;
    int  rdyViol    = 0;
    int  abortCount = 0;

    uart_tx_arb #(
        .N_SRC     (N),
        .HDR_EN    (1),
        .HDR_BASE  (8'hF0),
        .STALL_MAX (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .srst_i     (srst),
        .req_val_i  (reqVal),
        .req_data_i (reqData),
        .req_last_i (reqLast),
        .req_rdy_o  (reqRdy),
        .tx_val_o   (txVal),
        .tx_data_o  (txData),
        .tx_rdy_i   (txRdy),
        .tx_avail_i (txAvail),
        .grant_o    (grant),
        .busy_o     (busy),
        .abort_o    (abortP)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string what);
        checkCount++;
        $display("[TB] FAIL timeout %s: bound expired, required event not seen", what);
    endtask

    // Queue one byte on a source and, when expectOut is set, the matching
    // transmitter-side expectation (preceded by the header if hdrFirst).
    task automatic applyStimulus(input int src, input logic [7:0] data,
                                 input logic last, input logic hdrFirst,
                                 input logic expectOut);
        expItem_t e;
        srcItem_t s;
        logic [N-1:0] g;
        g = (src == 0) ? 2'b01 : 2'b10;
        if (hdrFirst) begin
            e.data  = 8'hF0 | 8'(src);
            e.grant = g;
            expQ.push_back(e);
        end
        s.data = data;
        s.last = last;
        if (src == 0) srcQ0.push_back(s);
        else          srcQ1.push_back(s);
        if (expectOut) begin
            e.data  = data;
            e.grant = g;
            expQ.push_back(e);
        end
    endtask

    task automatic waitExp(input int remaining, input int budget, input string what);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (expQ.size() <= remaining) ok = 1'b1;
        end
        if (!ok) timeoutFail(what);
    endtask

    task automatic waitIdle(input int budget, input string what);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) timeoutFail(what);
    endtask

    // Source drivers: a handshake seen at the negedge retires the queue
    // head just after the next posedge, then the new head is presented.
    // Valid stays up for as long as a source has bytes queued.
    always @(posedge clk) begin
        #1;
        if (hs[0] && srcQ0.size() > 0) void'(srcQ0.pop_front());
        if (hs[1] && srcQ1.size() > 0) void'(srcQ1.pop_front());
        reqVal[0]     = (srcQ0.size() > 0);
        reqData[7:0]  = (srcQ0.size() > 0) ? srcQ0[0].data : 8'h00;
        reqLast[0]    = (srcQ0.size() > 0) ? srcQ0[0].last : 1'b0;
        reqVal[1]     = (srcQ1.size() > 0);
        reqData[15:8] = (srcQ1.size() > 0) ? srcQ1[0].data : 8'h00;
        reqLast[1]    = (srcQ1.size() > 0) ? srcQ1[0].last : 1'b0;
    end

    // Transmitter ready pattern: always ready, ready 1 cycle in 3, or stalled.
    always @(posedge clk) begin
        #1;
        rdyCnt++;
        txRdy = (rdyMode == 0) || (rdyMode == 1 && (rdyCnt % 3) == 0);
    end

    // Monitor: samples mid-cycle, records source handshakes, tracks ready
    // exclusivity and abort pulses, and scores every transmitter transfer.
    always @(negedge clk) begin
        expItem_t e;
        hs = reqVal & reqRdy;
        if ($countones(reqRdy) > 1) rdyViol++;
        if (abortP) abortCount++;
        if (txVal && txRdy) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL txUnexpected: got byte %h grant %b, required no transfer",
                         txData, grant);
            end else begin
                e = expQ.pop_front();
                checkOutput("txByteGrant", {22'd0, grant, txData}, {22'd0, e.grant, e.data});
            end
        end
    end

    initial begin
        int  n;
        bit  found;
        int  abortBefore;

        // Reset state while rst_ni is held low.
        repeat (3) @(negedge clk);
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTx", {txVal, txData}, 0);
        checkOutput("rstRdyAbort", {reqRdy, abortP}, 0);
        @(posedge clk); #1 rstN = 1'b1;

        // Single source 0 packet 41,42 with header.
        $display("[TB] single source packet");
        @(negedge clk); #1;
        applyStimulus(0, 8'h41, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 8'h42, 1'b1, 1'b0, 1'b1);
        waitExp(0, 50, "t1Drain");
        waitIdle(20, "t1Idle");

        // Both sources busy; pointer is now 1 so source 1 goes first.
        $display("[TB] alternating sources");
        @(negedge clk); #1;
        applyStimulus(1, 8'h30, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h31, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 8'h20, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 8'h21, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 8'h34, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h35, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 8'h24, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 8'h25, 1'b1, 1'b0, 1'b1);
        waitExp(0, 100, "t2Drain");
        waitIdle(20, "t2Idle");

        // Back-pressure on source 1 packet, including a long full stall.
        $display("[TB] transmitter back-pressure");
        @(negedge clk); #1;
        rdyMode = 1;
        applyStimulus(1, 8'h10, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h11, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 8'h12, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 8'h13, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 8'h14, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 8'h15, 1'b1, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        #1;
        rdyMode = 2;
        abortBefore = abortCount;
        repeat (5000) @(negedge clk);
        checkOutput("bpNoAbort", abortCount - abortBefore, 0);
        checkOutput("bpHeld", {busy, grant}, 3'b110);
        #1;
        rdyMode = 1;
        waitExp(0, 100, "t3Drain");
        waitIdle(20, "t3Idle");
        #1;
        rdyMode = 0;

        // Source 0 stalls after one byte; watchdog aborts, source 1 follows.
        $display("[TB] stall watchdog");
        @(negedge clk); #1;
        applyStimulus(0, 8'h55, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h66, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h67, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (txVal && txRdy && txData == 8'h55) found = 1'b1;
        end
        if (!found) timeoutFail("stallFirstByte");
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            n++;
            if (abortP) found = 1'b1;
        end
        if (!found) timeoutFail("abortPulse");
        else        checkOutput("abortAt16", n, 16);
        @(negedge clk);
        checkOutput("abortGapBusy", busy, 0);
        checkOutput("abortGapGrant", grant, 0);
        checkOutput("abortPulseWidth", abortP, 0);
        @(negedge clk);
        checkOutput("afterAbortGrant", {busy, grant}, 3'b110);
        waitExp(0, 50, "t4Drain");
        waitIdle(20, "t4Idle");

        // Link unavailable: no start; raise it; lowering mid-packet is harmless.
        $display("[TB] link availability");
        @(posedge clk); #1 txAvail = 1'b0;
        @(negedge clk); #1;
        applyStimulus(0, 8'h70, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 8'h71, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 8'h80, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("availLow", {busy, grant}, 0);
        @(posedge clk); #1 txAvail = 1'b1;
        @(negedge clk);
        checkOutput("availRaiseSameCycle", grant, 0);
        @(negedge clk);
        checkOutput("availGrantNext", grant, 2'b01);
        @(posedge clk); #1 txAvail = 1'b0;
        waitExp(2, 50, "t5Src0Drain");
        repeat (4) @(negedge clk);
        checkOutput("availHoldOff", {busy, grant}, 0);
        @(posedge clk); #1 txAvail = 1'b1;
        waitExp(0, 50, "t5Drain");
        waitIdle(20, "t5Idle");

        // Move pointer to 1, then sync-reset in the middle of source 1 data.
        $display("[TB] synchronous reset mid-packet");
        @(negedge clk); #1;
        applyStimulus(0, 8'hC0, 1'b1, 1'b1, 1'b1);
        waitExp(0, 50, "t6Pre");
        waitIdle(20, "t6PreIdle");
        #1;
        applyStimulus(1, 8'h90, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 8'h91, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 8'h92, 1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (txVal && txData == 8'h90) found = 1'b1;
        end
        if (!found) timeoutFail("srstFirstByte");
        @(posedge clk); #1 srst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("srstGrantBusy", {busy, grant}, 0);
        checkOutput("srstTx", {txVal, txData}, 0);
        checkOutput("srstRdyAbort", {reqRdy, abortP}, 0);
        #1;
        srcQ1.delete();
        applyStimulus(0, 8'hA0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, 8'hB0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1 srst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("srstPtrZeroGrant", grant, 2'b01);
        waitExp(0, 50, "t6Drain");
        waitIdle(20, "t6Idle");

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        checkOutput("rdyOneHot", rdyViol, 0);
        checkOutput("totalAborts", abortCount, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
